even_pipe: RTL and testbench



---
 rtl/spu_pkg.sv | 46 ++++
 rtl/fx1_alu.sv | 54 +++++
 rtl/even_pipe.sv | 93 +++++++++
 tb/tb_even_pipe.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// Shared SPU definitions: unit ids, FX1 opcode ids and the packed stage-word layout.
// SV indices are LSB-first, so result bit 0 (MSB-first numbering) is index 142 of a stage word.
package spu_pkg;

  localparam int NUM_STAGES = 7;
  localparam int PACK_W     = 143;
  localparam int RES_W      = 128;

  localparam logic [2:0] UNIT_FX1 = 3'b000;

  localparam logic [6:0] OP_ADD  = 7'd1;
  localparam logic [6:0] OP_ADDI = 7'd2;
  localparam logic [6:0] OP_SUBF = 7'd3;
  localparam logic [6:0] OP_AND  = 7'd4;
  localparam logic [6:0] OP_OR   = 7'd5;
  localparam logic [6:0] OP_XOR  = 7'd6;
  localparam logic [6:0] OP_NOR  = 7'd7;
  localparam logic [6:0] OP_IL   = 7'd8;
  localparam logic [6:0] OP_ILA  = 7'd9;
  localparam logic [6:0] OP_SELB = 7'd10;
  localparam logic [6:0] OP_SHLI = 7'd11;

  // Field offsets within a stage word, counted from the LSB.
  localparam int PK_UNIT_LSB = 0;
  localparam int PK_LAT_LSB  = 3;
  localparam int PK_WE_BIT   = 7;
  localparam int PK_DST_LSB  = 8;
  localparam int PK_RES_LSB  = 15;

  typedef struct packed {
    logic [127:0] result;
    logic [6:0]   reg_dst;
    logic         wr_en;
    logic [3:0]   latency;
    logic [2:0]   unit_id;
  } pack_t;

  function automatic logic [31:0] shl32(input logic [31:0] a, input logic [5:0] cnt);
    if (cnt[5]) begin
      shl32 = 32'd0;
    end else begin
      shl32 = a << cnt[4:0];
    end
  endfunction

endpackage

// File: rtl/fx1_alu.sv
// FX1 simple fixed-point unit: purely combinational, four independent 32-bit word lanes.
module fx1_alu (
  input  logic [6:0]   instr_id,
  input  logic [127:0] ra,
  input  logic [127:0] rb,
  input  logic [127:0] rc,
  input  logic [7:0]   imme7,
  input  logic [9:0]   imme10,
  input  logic [15:0]  imme16,
  input  logic [17:0]  imme18,
  output logic [127:0] result
);
  import spu_pkg::*;

  // Only the low six bits of imme7 form the shift count.
  logic unused_imm_s;
  assign unused_imm_s = ^imme7[7:6];

  function automatic logic [31:0] lane_op(
    input logic [6:0]  id,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] c,
    input logic [5:0]  sh,
    input logic [9:0]  i10,
    input logic [15:0] i16,
    input logic [17:0] i18
  );
    case (id)
      OP_ADD:  lane_op = a + b;
      OP_ADDI: lane_op = a + {{22{i10[9]}}, i10};
      OP_SUBF: lane_op = b - a;
      OP_AND:  lane_op = a & b;
      OP_OR:   lane_op = a | b;
      OP_XOR:  lane_op = a ^ b;
      OP_NOR:  lane_op = ~(a | b);
      OP_IL:   lane_op = {{16{i16[15]}}, i16};
      OP_ILA:  lane_op = {14'd0, i18};
      OP_SELB: lane_op = (c & b) | (~c & a);
      OP_SHLI: lane_op = shl32(a, sh);
      default: lane_op = 32'd0;
    endcase
  endfunction

  // Per-lane evaluation; no carries cross the 32-bit lane boundaries.
  always_comb begin
    result = 128'd0;
    for (int k = 0; k < 4; k++) begin
      result[32*k +: 32] = lane_op(instr_id, ra[32*k +: 32], rb[32*k +: 32], rc[32*k +: 32],
                                   imme7[5:0], imme10, imme16, imme18);
    end
  end

endmodule

// File: rtl/even_pipe.sv
// Even-side SPU pipeline: FX1 result in stage 1, then a 7-deep shift chain; last stage feeds write-back.
module even_pipe #(
  parameter int STAGES = 7,
  parameter int PACK_W = 143
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        full_instr,
  input  logic [6:0]         instr_id,
  input  logic [6:0]         reg_dst,
  input  logic [2:0]         unit_id,
  input  logic [3:0]         latency,
  input  logic               reg_wr,
  input  logic [127:0]       ra_data,
  input  logic [127:0]       rb_data,
  input  logic [127:0]       rc_data,
  input  logic [7:0]         imme7,
  input  logic [9:0]         imme10,
  input  logic [15:0]        imme16,
  input  logic [17:0]        imme18,
  output logic [PACK_W-1:0]  packed_1stage,
  output logic [PACK_W-1:0]  packed_2stage,
  output logic [PACK_W-1:0]  packed_3stage,
  output logic [PACK_W-1:0]  packed_4stage,
  output logic [PACK_W-1:0]  packed_5stage,
  output logic [PACK_W-1:0]  packed_6stage,
  output logic [PACK_W-1:0]  packed_7stage,
  output logic [6:0]         WB_reg_write_addr,
  output logic [127:0]       WB_reg_write_data,
  output logic               WB_reg_write_en
);
  import spu_pkg::*;

  // The raw instruction word is kept on the port for debug visibility only.
  logic unused_s;
  assign unused_s = ^full_instr;

  logic [127:0]      alu_res_s;
  pack_t             pack_d;
  logic [PACK_W-1:0] stage_q [STAGES];

  fx1_alu u_fx1 (
    .instr_id (instr_id),
    .ra       (ra_data),
    .rb       (rb_data),
    .rc       (rc_data),
    .imme7    (imme7),
    .imme10   (imme10),
    .imme16   (imme16),
    .imme18   (imme18),
    .result   (alu_res_s)
  );

  // Unit gating: any unit id other than FX1 yields a zero result with write-back suppressed.
  always_comb begin
    pack_d.reg_dst = reg_dst;
    pack_d.latency = latency;
    pack_d.unit_id = unit_id;
    if (unit_id == UNIT_FX1) begin
      pack_d.result = alu_res_s;
      pack_d.wr_en  = reg_wr;
    end else begin
      pack_d.result = 128'd0;
      pack_d.wr_en  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= {PACK_W{1'b0}};
      end
    end else begin
      stage_q[0] <= pack_d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign packed_1stage = stage_q[0];
  assign packed_2stage = stage_q[1];
  assign packed_3stage = stage_q[2];
  assign packed_4stage = stage_q[3];
  assign packed_5stage = stage_q[4];
  assign packed_6stage = stage_q[5];
  assign packed_7stage = stage_q[STAGES-1];

  assign WB_reg_write_addr = packed_7stage[PK_DST_LSB +: 7];
  assign WB_reg_write_data = packed_7stage[PK_RES_LSB +: RES_W];
  assign WB_reg_write_en   = packed_7stage[PK_WE_BIT];

endmodule

// File: tb/tb_even_pipe.sv
// Scoreboard bench for even_pipe: issue pushes the expected write-back, a negedge monitor pops and compares.
module tb_even_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  full_instr;
  logic [6:0]   instr_id, reg_dst;
  logic [2:0]   unit_id;
  logic [3:0]   latency;
  logic         reg_wr;
  logic [127:0] ra_data, rb_data, rc_data;
  logic [7:0]   imme7;
  logic [9:0]   imme10;
  logic [15:0]  imme16;
  logic [17:0]  imme18;
  logic [142:0] p1, p2, p3, p4, p5, p6, p7;
  logic [6:0]   wb_addr;
  logic [127:0] wb_data;
  logic         wb_en;

  even_pipe dut (
    .clk(clk), .rst(rst), .full_instr(full_instr), .instr_id(instr_id), .reg_dst(reg_dst),
    .unit_id(unit_id), .latency(latency), .reg_wr(reg_wr), .ra_data(ra_data), .rb_data(rb_data),
    .rc_data(rc_data), .imme7(imme7), .imme10(imme10), .imme16(imme16), .imme18(imme18),
    .packed_1stage(p1), .packed_2stage(p2), .packed_3stage(p3), .packed_4stage(p4),
    .packed_5stage(p5), .packed_6stage(p6), .packed_7stage(p7),
    .WB_reg_write_addr(wb_addr), .WB_reg_write_data(wb_data), .WB_reg_write_en(wb_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic [6:0]   addr;
    logic [127:0] data;
    logic         en;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares write-back against every expectation that has come due.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.due != cyc || wb_addr !== e.addr || wb_data !== e.data || wb_en !== e.en) begin
          errors++;
          $display("FAIL wb due=%0d cyc=%0d addr got %h want %h data got %h want %h en got %b want %b",
                   e.due, cyc, wb_addr, e.addr, wb_data, e.data, wb_en, e.en);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [142:0] act, input logic [142:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [6:0] id, input logic [6:0] dst, input logic [2:0] unit,
                       input logic [3:0] lat, input logic wr,
                       input logic [127:0] a, input logic [127:0] b, input logic [127:0] c,
                       input logic [7:0] i7, input logic [9:0] i10, input logic [15:0] i16,
                       input logic [17:0] i18, input logic [127:0] exp_d, input logic exp_en);
    full_instr = $urandom;
    instr_id = id; reg_dst = dst; unit_id = unit; latency = lat; reg_wr = wr;
    ra_data = a; rb_data = b; rc_data = c;
    imme7 = i7; imme10 = i10; imme16 = i16; imme18 = i18;
    sb.push_back('{cyc + 7, dst, exp_d, exp_en});
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    issue(7'd0, 7'd0, 3'b001, 4'd0, 1'b0, 128'd0, 128'd0, 128'd0, 8'd0, 10'd0, 16'd0, 18'd0,
          128'd0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_p1"}, p1, 143'd0); chk({tag, "_p2"}, p2, 143'd0); chk({tag, "_p3"}, p3, 143'd0);
    chk({tag, "_p4"}, p4, 143'd0); chk({tag, "_p5"}, p5, 143'd0); chk({tag, "_p6"}, p6, 143'd0);
    chk({tag, "_p7"}, p7, 143'd0);
    chk({tag, "_wb"}, {8'd0, wb_addr, wb_data, wb_en}, 143'd0);
  endtask

  logic [127:0] r33, r03, r1f, f0, ff00, z;

  initial begin
    r33  = {4{32'h33333333}};
    r03  = {4{32'h03030303}};
    r1f  = {4{32'h1FFFFFFF}};
    f0   = {4{32'hF0F0F0F0}};
    ff00 = {4{32'hFF00FF00}};
    z    = 128'd0;

    // Reset with arbitrary inputs applied
    rst = 1'b1;
    full_instr = $urandom; instr_id = 7'd1; reg_dst = 7'd99; unit_id = 3'b000; latency = 4'd5;
    reg_wr = 1'b1; ra_data = {4{32'h12345678}}; rb_data = {4{32'h9ABCDEF0}}; rc_data = z;
    imme7 = 8'd3; imme10 = 10'd5; imme16 = 16'd7; imme18 = 18'd9;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Back-to-back adds
    issue(7'd1, 7'd7, 3'b000, 4'd2, 1'b1, {4{32'h11111111}}, {4{32'h22222222}}, z,
          8'd0, 10'd0, 16'd0, 18'd0, r33, 1'b1);
    chk("add_p1", p1, {r33, 7'd7, 1'b1, 4'b0010, 3'b000});
    issue(7'd1, 7'd8, 3'b000, 4'd2, 1'b1, {4{32'h01010101}}, {4{32'h02020202}}, z,
          8'd0, 10'd0, 16'd0, 18'd0, r03, 1'b1);
    issue(7'd1, 7'd9, 3'b000, 4'd2, 1'b1, {4{32'h10000000}}, {4{32'h0FFFFFFF}}, z,
          8'd0, 10'd0, 16'd0, 18'd0, r1f, 1'b1);
    chk("b2b_p3", p3, {r33, 7'd7, 1'b1, 4'b0010, 3'b000});
    chk("b2b_p2", p2, {r03, 7'd8, 1'b1, 4'b0010, 3'b000});
    chk("b2b_p1", p1, {r1f, 7'd9, 1'b1, 4'b0010, 3'b000});

    // Lane wrap without carry into neighbour lanes
    issue(7'd1, 7'd10, 3'b000, 4'd2, 1'b1, {32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0},
          {4{32'h00000001}}, z, 8'd0, 10'd0, 16'd0, 18'd0,
          {32'h0, 32'h1, 32'h0, 32'h1}, 1'b1);
    issue(7'd2, 7'd11, 3'b000, 4'd2, 1'b1, {4{32'h11111111}}, z, z,
          8'd0, 10'h3FF, 16'd0, 18'd0, {4{32'h11111110}}, 1'b1);
    issue(7'd3, 7'd12, 3'b000, 4'd2, 1'b1, {4{32'h00000001}}, z, z,
          8'd0, 10'd0, 16'd0, 18'd0, {4{32'hFFFFFFFF}}, 1'b1);
    issue(7'd4, 7'd13, 3'b000, 4'd2, 1'b1, f0, ff00, z, 8'd0, 10'd0, 16'd0, 18'd0,
          {4{32'hF000F000}}, 1'b1);
    issue(7'd5, 7'd14, 3'b000, 4'd2, 1'b1, f0, ff00, z, 8'd0, 10'd0, 16'd0, 18'd0,
          {4{32'hFFF0FFF0}}, 1'b1);
    issue(7'd6, 7'd15, 3'b000, 4'd2, 1'b1, f0, ff00, z, 8'd0, 10'd0, 16'd0, 18'd0,
          {4{32'h0FF00FF0}}, 1'b1);
    issue(7'd7, 7'd16, 3'b000, 4'd2, 1'b1, f0, ff00, z, 8'd0, 10'd0, 16'd0, 18'd0,
          {4{32'h000F000F}}, 1'b1);
    issue(7'd8, 7'd17, 3'b000, 4'd2, 1'b1, z, z, z, 8'd0, 10'd0, 16'hBEEF, 18'd0,
          {4{32'hFFFFBEEF}}, 1'b1);
    issue(7'd9, 7'd18, 3'b000, 4'd2, 1'b1, z, z, z, 8'd0, 10'd0, 16'd0, 18'h2AAAA,
          {4{32'h0002AAAA}}, 1'b1);
    issue(7'd10, 7'd19, 3'b000, 4'd2, 1'b1, {4{32'h55555555}}, {4{32'hAAAAAAAA}},
          {4{32'hFFFF0000}}, 8'd0, 10'd0, 16'd0, 18'd0, {4{32'hAAAA5555}}, 1'b1);
    issue(7'd11, 7'd20, 3'b000, 4'd2, 1'b1, {4{32'h00000001}}, z, z,
          8'd4, 10'd0, 16'd0, 18'd0, {4{32'h00000010}}, 1'b1);
    issue(7'd11, 7'd21, 3'b000, 4'd2, 1'b1, {4{32'h00000001}}, z, z,
          8'd32, 10'd0, 16'd0, 18'd0, z, 1'b1);
    issue(7'd11, 7'd22, 3'b000, 4'd2, 1'b1, {4{32'h00000001}}, z, z,
          8'hC4, 10'd0, 16'd0, 18'd0, {4{32'h00000010}}, 1'b1);
    issue(7'd11, 7'd23, 3'b000, 4'd2, 1'b1, {4{32'h00000003}}, z, z,
          8'd31, 10'd0, 16'd0, 18'd0, {4{32'h80000000}}, 1'b1);

    // Unsupported opcode and non-FX1 unit
    issue(7'd85, 7'd24, 3'b000, 4'd3, 1'b1, f0, ff00, z, 8'd0, 10'd0, 16'd0, 18'd0, z, 1'b1);
    issue(7'd85, 7'd25, 3'b001, 4'd3, 1'b1, f0, ff00, z, 8'd0, 10'd0, 16'd0, 18'd0, z, 1'b0);
    issue(7'd1, 7'd26, 3'b010, 4'd3, 1'b1, {4{32'h11111111}}, {4{32'h22222222}}, z,
          8'd0, 10'd0, 16'd0, 18'd0, z, 1'b0);
    repeat (7) bubble();

    // Mid-flight asynchronous reset
    issue(7'd1, 7'd30, 3'b000, 4'd2, 1'b1, {4{32'h11111111}}, {4{32'h22222222}}, z,
          8'd0, 10'd0, 16'd0, 18'd0, r33, 1'b1);
    issue(7'd1, 7'd31, 3'b000, 4'd2, 1'b1, {4{32'h01010101}}, {4{32'h02020202}}, z,
          8'd0, 10'd0, 16'd0, 18'd0, r03, 1'b1);
    chk("pre_rst_p2", p2, {r33, 7'd30, 1'b1, 4'b0010, 3'b000});
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) bubble();

    // Drain with a bounded wait
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
